// File: rtl/pclock_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pclock_gen_pkg
// Description : Shared types and constants for the pclock_gen clock-pattern
//               generator (state encoding, configuration record, clamp rule).
// Revision    : 1.0 - initial release
// ============================================================================
package pclock_gen_pkg;

    // Width of each configuration field; a wider DW port is truncated to this.
    localparam int c_PCLK_DW = 8;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PHASE  = 2'd1;
    localparam logic [1:0] c_ST_WARMUP = 2'd2;
    localparam logic [1:0] c_ST_RUN    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = c_ST_IDLE,
        S_PHASE  = c_ST_PHASE,
        S_WARMUP = c_ST_WARMUP,
        S_RUN    = c_ST_RUN
    } pclock_state_e;

    typedef struct packed {
        logic [c_PCLK_DW-1:0] div;
        logic [c_PCLK_DW-1:0] high;
        logic [c_PCLK_DW-1:0] phase;
    } pclock_cfg_t;

    localparam pclock_cfg_t c_CFG_RESET = '{
        div:   c_PCLK_DW'(1),
        high:  c_PCLK_DW'(1),
        phase: '0
    };

    // div of 0 behaves as 1; high is forced into 1..div so the output toggles.
    function automatic pclock_cfg_t pclock_clamp(
        input logic [c_PCLK_DW-1:0] div,
        input logic [c_PCLK_DW-1:0] high,
        input logic [c_PCLK_DW-1:0] phase
    );
        pclock_cfg_t w_cfg;
        w_cfg.div   = (div == '0) ? c_PCLK_DW'(1) : div;
        w_cfg.high  = (high == '0) ? c_PCLK_DW'(1)
                    : ((high > w_cfg.div) ? w_cfg.div : high);
        w_cfg.phase = phase;
        return w_cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pclock_cfg_sync.sv
`default_nettype none
// ============================================================================
// Module      : pclock_cfg_sync
// Description : Configuration handshake, clamp and pending register for
//               pclock_gen. Optional macro: PCLOCK_GEN_PHASE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pclock_cfg_sync
    import pclock_gen_pkg::*;
#(
    parameter int DW = c_PCLK_DW
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_div,
    input  logic [DW-1:0] cfg_high,
    input  logic [DW-1:0] cfg_phase,
    input  logic          idle,
    input  logic          go_idle,
    input  logic          wrap,
    output logic          apply,
    output pclock_cfg_t   act,
    output pclock_cfg_t   act_nxt
);

    pclock_cfg_t          r_act;
    pclock_cfg_t          r_pend;
    logic                 r_pend_vld;
    logic                 r_ready;
    pclock_cfg_t          w_new;
    pclock_cfg_t          w_act_nxt;
    pclock_cfg_t          w_pend_nxt;
    logic                 w_pend_vld_nxt;
    logic                 w_accept;
    logic [c_PCLK_DW-1:0] w_raw_phase;

`ifdef PCLOCK_GEN_PHASE_EN
    assign w_raw_phase = c_PCLK_DW'(cfg_phase);
`else
    logic w_unused_phase;
    assign w_unused_phase = ^cfg_phase;
    assign w_raw_phase    = '0;
`endif

    assign w_new    = pclock_clamp(c_PCLK_DW'(cfg_div), c_PCLK_DW'(cfg_high), w_raw_phase);
    assign w_accept = cfg_valid && r_ready;
    assign apply    = r_pend_vld && wrap;

    always_comb begin
        w_act_nxt      = r_act;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        if (idle) begin
            if (w_accept) w_act_nxt = w_new;
        end else if (go_idle) begin
            // Leaving for IDLE: whatever was offered last becomes active now.
            w_pend_vld_nxt = 1'b0;
            if (w_accept)        w_act_nxt = w_new;
            else if (r_pend_vld) w_act_nxt = r_pend;
        end else if (apply) begin
            w_act_nxt      = r_pend;
            w_pend_vld_nxt = 1'b0;
        end else if (w_accept) begin
            w_pend_nxt     = w_new;
            w_pend_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_act      <= c_CFG_RESET;
            r_pend     <= c_CFG_RESET;
            r_pend_vld <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_act      <= w_act_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_ready    <= !w_pend_vld_nxt;
        end
    end

    assign act       = r_act;
    assign act_nxt   = w_act_nxt;
    assign cfg_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/pclock_gen.sv
`default_nettype none
// ============================================================================
// Module      : pclock_gen
// Description : Programmable divided clock / strobe generator with glitch-free
//               reconfiguration and lock flag. Optional macro: PCLOCK_GEN_PHASE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pclock_gen
    import pclock_gen_pkg::*;
#(
    parameter int DW     = c_PCLK_DW,
    parameter int WARMUP = 100          // must be at least 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_div,
    input  logic [DW-1:0] cfg_high,
    input  logic [DW-1:0] cfg_phase,
    output logic          gclk_out,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic          locked
);

    localparam int              c_PW        = $clog2(WARMUP + 1);
    localparam logic [c_PW-1:0] c_WARM_LAST = c_PW'(WARMUP - 1);
    localparam logic [c_PW-1:0] c_WARM_MAX  = c_PW'(WARMUP);

    pclock_state_e        r_state;
    pclock_state_e        w_state_nxt;
    pclock_state_e        w_start_state;
    pclock_cfg_t          w_act;
    pclock_cfg_t          w_act_nxt;
    logic [c_PCLK_DW-1:0] r_cnt;
    logic [c_PW-1:0]      r_pcnt;
    logic                 w_idle;
    logic                 w_go_idle;
    logic                 w_gen;
    logic                 w_wrap;
    logic                 w_apply;

    assign w_idle    = (r_state == S_IDLE);
    assign w_go_idle = !w_idle && !enable;
    assign w_gen     = enable && ((r_state == S_WARMUP) || (r_state == S_RUN));
    assign w_wrap    = w_gen && (r_cnt == w_act.div);

    pclock_cfg_sync #(
        .DW (DW)
    ) u_cfg (
        .clock     (clock),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .idle      (w_idle),
        .go_idle   (w_go_idle),
        .wrap      (w_wrap),
        .apply     (w_apply),
        .act       (w_act),
        .act_nxt   (w_act_nxt)
    );

`ifdef PCLOCK_GEN_PHASE_EN
    logic [c_PCLK_DW-1:0] r_phcnt;
    logic                 w_phase_done;

    // Decided on the configuration that becomes active at this same edge.
    assign w_start_state = (w_act_nxt.phase != '0) ? S_PHASE : S_WARMUP;
    assign w_phase_done  = (r_phcnt == (w_act.phase - c_PCLK_DW'(1)));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_phcnt <= '0;
        else if ((r_state == S_PHASE) && enable)
            r_phcnt <= r_phcnt + c_PCLK_DW'(1);
        else
            r_phcnt <= '0;
    end
`else
    logic w_unused_phase;
    assign w_unused_phase = ^{w_act.phase, w_act_nxt.phase};
    assign w_start_state  = S_WARMUP;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nxt = w_start_state;
`ifdef PCLOCK_GEN_PHASE_EN
            S_PHASE:  if (w_phase_done) w_state_nxt = S_WARMUP;
`endif
            S_WARMUP: if (w_wrap && (r_pcnt == c_WARM_LAST)) w_state_nxt = S_RUN;
            S_RUN:    w_state_nxt = S_RUN;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_go_idle)
            w_state_nxt = S_IDLE;
        else if (w_apply)
            w_state_nxt = w_start_state;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pcnt     <= '0;
            gclk_out   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gen && !w_apply) begin
                r_cnt <= w_wrap ? '0 : (r_cnt + c_PCLK_DW'(1));
                if (w_wrap && (r_pcnt != c_WARM_MAX))
                    r_pcnt <= r_pcnt + c_PW'(1);
            end else begin
                r_cnt  <= '0;
                r_pcnt <= '0;
            end
            // The apply edge still emits the last cycle of the old period.
            gclk_out   <= w_gen && (r_cnt < w_act.high);
            rise_pulse <= w_gen && (r_cnt == '0);
            fall_pulse <= w_gen && (r_cnt == w_act.high);
            // Rises one edge after entering RUN, drops on the edge leaving it.
            locked     <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
        end
    end

endmodule
`default_nettype wire
